// File: rtl/sc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sc_pkg
//  Description : Shared definitions for the stochastic bipolar decoder:
//                default widths, FSM state encoding, window-length decode
//                and the EMA shift amount.
//  Revision    : 1.0 - initial release
// ============================================================================
package sc_pkg;

    localparam int SC_CNT_W          = 7;  // ones count, 0..64
    localparam int SC_VAL_W          = 8;  // signed bipolar value, -64..+64
    localparam int SC_WIN_W          = 7;  // window length, 8..64
    localparam int SC_DEC_EMA_SHIFT  = 2;  // EMA smoothing factor 1/4

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } sc_state_e;

    // W = 2^(win_sel+3): 8, 16, 32, 64
    function automatic logic [SC_WIN_W-1:0] win_len_decode(input logic [1:0] sel);
        return 7'd8 << sel;
    endfunction

endpackage : sc_pkg
`default_nettype wire

// File: rtl/sc_win_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sc_win_counter
//  Description : Valid-sample counter and ones accumulator for one decode
//                window. Flags the terminal sample and presents the total
//                including that sample.
//  Revision    : 1.0 - initial release
// ============================================================================
module sc_win_counter
    import sc_pkg::*;
#(
    parameter int CNT_W = SC_CNT_W
) (
    input  logic                clk,
    input  logic                rst_n,      // asynchronous, active-high
    input  logic                clr_i,      // discard the running window
    input  logic                inc_i,      // a qualified sample is present
    input  logic                bit_i,
    input  logic [SC_WIN_W-1:0] win_len_i,
    output logic [CNT_W-1:0]    ones_o,     // accumulator plus current bit
    output logic                tc_o        // current sample closes the window
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] w_last;

    assign w_last = CNT_W'(win_len_i) - CNT_W'(1);
    assign tc_o   = inc_i && (cnt_q == w_last);
    assign ones_o = acc_q + CNT_W'(bit_i);

    // Next count: clear on discard or window close, otherwise advance per sample
    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        if (clr_i) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (inc_i) begin
            if (tc_o) begin
                cnt_d = '0;
                acc_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                acc_d = ones_o;
            end
        end
    end

    // Counter state registers
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

endmodule : sc_win_counter
`default_nettype wire

// File: rtl/sc_bipolar_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : sc_bipolar_decoder
//  Description : Windowed bipolar stochastic-stream decoder. Counts ones over
//                8/16/32/64 valid samples and reports the ones count and the
//                signed value 2*ones - W at each window boundary.
//                Optional EMA smoothing of the bipolar value is enabled by
//                defining SC_DEC_EMA_EN; otherwise ema_val is tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module sc_bipolar_decoder
    import sc_pkg::*;
#(
    parameter int CNT_W = SC_CNT_W,
    parameter int VAL_W = SC_VAL_W
) (
    input  logic                clk,
    input  logic                rst_n,      // asynchronous, active-high
    input  logic                en,
    input  logic [1:0]          win_sel,
    input  logic                sn_bit,
    input  logic                sn_valid,
    output logic [CNT_W-1:0]    ones_cnt,
    output logic [VAL_W-1:0]    bip_val,
    output logic [SC_WIN_W-1:0] win_len,
    output logic                out_valid,
    output logic [VAL_W-1:0]    ema_val
);

    sc_state_e             state_q, state_d;
    logic [SC_WIN_W-1:0]   win_q, win_d;       // W of the window in progress

    logic                  w_clr;
    logic                  w_inc;
    logic                  w_done;
    logic [CNT_W-1:0]      w_ones;
    logic [VAL_W:0]        w_bip_wide;
    logic [VAL_W-1:0]      w_bip_new;
    logic                  w_bip_msb_unused;

    logic [CNT_W-1:0]      ones_q, ones_d;
    logic [VAL_W-1:0]      bip_q, bip_d;
    logic [SC_WIN_W-1:0]   winlen_q, winlen_d;
    logic                  ov_q, ov_d;

    // en low wins over everything, including a completing sample
    assign w_clr = (state_q != ST_ACCUM) || !en;
    assign w_inc = (state_q == ST_ACCUM) && en && sn_valid;

    sc_win_counter #(
        .CNT_W     (CNT_W)
    ) u_win_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (w_clr),
        .inc_i     (w_inc),
        .bit_i     (sn_bit),
        .win_len_i (win_q),
        .ones_o    (w_ones),
        .tc_o      (w_done)
    );

    // 2*ones - W never leaves the VAL_W range, so the extra bit is dropped
    assign w_bip_wide       = ((VAL_W+1)'(w_ones) << 1) - (VAL_W+1)'(win_q);
    assign w_bip_new        = w_bip_wide[VAL_W-1:0];
    assign w_bip_msb_unused = w_bip_wide[VAL_W];

    // Next state and window-length latch; W is sampled at start and at each close
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_ACCUM;
                    win_d   = win_len_decode(win_sel);
                end
            end
            ST_ACCUM: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (w_done) begin
                    win_d   = win_len_decode(win_sel);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Result registers load on window close and hold otherwise
    always_comb begin
        ones_d   = ones_q;
        bip_d    = bip_q;
        winlen_d = winlen_q;
        ov_d     = 1'b0;
        if (w_done) begin
            ones_d   = w_ones;
            bip_d    = w_bip_new;
            winlen_d = win_q;
            ov_d     = 1'b1;
        end
    end

    // State and result registers
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q  <= ST_IDLE;
            win_q    <= '0;
            ones_q   <= '0;
            bip_q    <= '0;
            winlen_q <= '0;
            ov_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            ones_q   <= ones_d;
            bip_q    <= bip_d;
            winlen_q <= winlen_d;
            ov_q     <= ov_d;
        end
    end

    assign ones_cnt  = ones_q;
    assign bip_val   = bip_q;
    assign win_len   = winlen_q;
    assign out_valid = ov_q;

`ifdef SC_DEC_EMA_EN
    logic [VAL_W-1:0]      ema_q, ema_d;
    logic signed [VAL_W:0] w_ema_diff;
    logic signed [VAL_W:0] w_ema_step;
    logic                  w_ema_msb_unused;

    // Difference and shift use one guard bit so the subtraction cannot wrap
    assign w_ema_diff       = $signed({w_bip_new[VAL_W-1], w_bip_new})
                            - $signed({ema_q[VAL_W-1], ema_q});
    assign w_ema_step       = w_ema_diff >>> SC_DEC_EMA_SHIFT;
    assign w_ema_msb_unused = w_ema_step[VAL_W];

    // EMA advances in the same cycle the bipolar value is captured
    always_comb begin
        ema_d = ema_q;
        if (w_done) begin
            ema_d = ema_q + w_ema_step[VAL_W-1:0];
        end
    end

    // EMA register
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            ema_q <= '0;
        end else begin
            ema_q <= ema_d;
        end
    end

    assign ema_val = ema_q;
`else
    assign ema_val = '0;
`endif

endmodule : sc_bipolar_decoder
`default_nettype wire

// File: tb/tb_sc_bipolar_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sc_bipolar_decoder
//  Description : Directed scoreboard bench for sc_bipolar_decoder. Stimulus
//                pushes expected window results; a monitor pops and compares
//                on every out_valid pulse, including the pulse cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sc_bipolar_decoder;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] win_sel;
    logic       sn_bit;
    logic       sn_valid;
    logic [6:0] ones_cnt;
    logic [7:0] bip_val;
    logic [6:0] win_len;
    logic       out_valid;
    logic [7:0] ema_val;

    sc_bipolar_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .win_sel   (win_sel),
        .sn_bit    (sn_bit),
        .sn_valid  (sn_valid),
        .ones_cnt  (ones_cnt),
        .bip_val   (bip_val),
        .win_len   (win_len),
        .out_valid (out_valid),
        .ema_val   (ema_val)
    );

    typedef struct {
        int ones;
        int bip;
        int wl;
        int ema;
        int cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_pulses = 0;
    int   n_pushed = 0;
    int   cyc      = 0;
    int   ema_m    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_checks++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    endtask

    function automatic int ema_step(input int ema, input int bip);
`ifdef SC_DEC_EMA_EN
        int d;
        d = bip - ema;
        return ema + (d >>> 2);
`else
        return 0;
`endif
    endfunction

    // Scoreboard monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (out_valid) begin
            exp_t e;
            n_pulses++;
            if (sb_q.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("ones_cnt",  int'(ones_cnt),          e.ones);
                chk("bip_val",   int'($signed(bip_val)),  e.bip);
                chk("win_len",   int'(win_len),           e.wl);
                chk("ema_val",   int'($signed(ema_val)),  e.ema);
                chk("pulse_cyc", cyc,                     e.cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b, input logic v);
        sn_bit   = b;
        sn_valid = v;
        step();
    endtask

    // Called right after the edge that captures the closing sample
    task automatic expect_win(input int ones, input int bip, input int wl);
        exp_t e;
        ema_m  = ema_step(ema_m, bip);
        e.ones = ones;
        e.bip  = bip;
        e.wl   = wl;
        e.ema  = ema_m;
        e.cyc  = cyc;
        sb_q.push_back(e);
        n_pushed++;
    endtask

    task automatic start_win(input logic [1:0] sel);
        en       = 1'b0;
        sn_valid = 1'b0;
        step();
        win_sel  = sel;
        en       = 1'b1;
        step();
    endtask

    initial begin
        rst_n    = 1'b1;
        en       = 1'b0;
        win_sel  = 2'd0;
        sn_bit   = 1'b0;
        sn_valid = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        step();
        chk("rst_ones", int'(ones_cnt), 0);
        chk("rst_bip",  int'(bip_val),  0);
        chk("rst_wl",   int'(win_len),  0);
        chk("rst_ov",   int'(out_valid), 0);
        chk("rst_ema",  int'(ema_val),  0);

        // W=8, all ones
        start_win(2'd0);
        for (int i = 0; i < 8; i++) send(1'b1, 1'b1);
        expect_win(8, 8, 8);

        // W=16 alternating, two windows back-to-back
        start_win(2'd1);
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 16; i++) send(((i % 2) == 0), 1'b1);
            expect_win(8, 0, 16);
        end

        // W=64 all zeros
        start_win(2'd3);
        for (int i = 0; i < 64; i++) send(1'b0, 1'b1);
        expect_win(0, -64, 64);

        // W=8 with sn_valid every other cycle: window stretches to 15 cycles
        start_win(2'd0);
        for (int i = 0; i < 16; i++) begin
            send(1'b1, ((i % 2) == 0));
            if (i == 14) expect_win(8, 8, 8);
        end

        // win_sel changes mid-window: current stays W=8, next is W=32
        start_win(2'd0);
        for (int i = 0; i < 4; i++) send(1'b1, 1'b1);
        win_sel = 2'd2;
        for (int i = 0; i < 4; i++) send(1'b1, 1'b1);
        expect_win(8, 8, 8);
        for (int i = 0; i < 32; i++) send((i < 24), 1'b1);
        expect_win(24, 16, 32);

        // Asynchronous reset mid-window clears outputs immediately
        start_win(2'd0);
        for (int i = 0; i < 5; i++) send(1'b1, 1'b1);
        sn_valid = 1'b0;
        rst_n    = 1'b1;
        #2;
        chk("arst_ones", int'(ones_cnt),  0);
        chk("arst_bip",  int'(bip_val),   0);
        chk("arst_wl",   int'(win_len),   0);
        chk("arst_ov",   int'(out_valid), 0);
        chk("arst_ema",  int'(ema_val),   0);
        ema_m = 0;
        step();
        rst_n = 1'b0;

        // Three +8 windows of post-reset samples only (EMA 2, 3, 4 when enabled)
        start_win(2'd0);
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 8; i++) send(1'b1, 1'b1);
            expect_win(8, 8, 8);
        end
`ifdef SC_DEC_EMA_EN
        chk("ema_hand", ema_m, 4);
`endif

        // en drops on the closing sample: no pulse, window discarded
        start_win(2'd0);
        for (int i = 0; i < 7; i++) send(1'b1, 1'b1);
        en = 1'b0;
        send(1'b1, 1'b1);
        sn_valid = 1'b0;
        repeat (3) step();

        // Fresh window after discard
        start_win(2'd0);
        for (int i = 0; i < 8; i++) send((i < 2), 1'b1);
        expect_win(2, -4, 8);

        // Outputs hold between pulses
        sn_valid = 1'b0;
        repeat (5) step();
        chk("hold_ones", int'(ones_cnt),         2);
        chk("hold_bip",  int'($signed(bip_val)), -4);
        chk("hold_wl",   int'(win_len),          8);
        chk("hold_ov",   int'(out_valid),        0);
        chk("sb_empty",  sb_q.size(),            0);
        chk("pulse_count", n_pulses,             n_pushed);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_sc_bipolar_decoder
`default_nettype wire

// File: doc/sc_bipolar_decoder.md
# sc_bipolar_decoder

Downstream stage of the stochastic multiplier. It consumes a bipolar stochastic bitstream (one bit per valid cycle) and counts ones over a programmable window of 8/16/32/64 samples. At each window boundary it emits the unsigned ones count and the signed bipolar value 2·ones − W. It replaces the fixed 8-cycle up-counter with a windowed, gap-tolerant decoder that has a handshake-qualified input.

## Interface
Parameters:
- CNT_W, 7, width of ones count (holds 0..64)
- VAL_W, 8, width of signed bipolar value (holds −64..+64)

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous, active-high reset (port keeps the codebase name; asserted = 1)
- en  in  1  decoder enable; low forces IDLE and clears window state
- win_sel  in  2  window length select, W = 2^(win_sel+3)
- sn_bit  in  1  stochastic bit
- sn_valid  in  1  sn_bit qualifier; the bit is counted only when high
- ones_cnt  out  CNT_W  ones in last completed window
- bip_val  out  VAL_W  signed 2·ones_cnt − W of last window
- win_len  out  7  W used for last completed window
- out_valid  out  1  one-cycle pulse when outputs update
- ema_val  out  VAL_W  smoothed bip_val (see Configuration)

## Operation
- FSM states IDLE, ACCUM.
  - IDLE → ACCUM when en = 1.
  - ACCUM → IDLE when en = 0. The partial window is discarded and no out_valid is produced.
- On IDLE→ACCUM and at every window completion, win_sel is latched into the active window length. A win_sel change mid-window takes effect only at the next window start.
- In ACCUM, each cycle with sn_valid = 1:
  - sample counter increments;
  - ones accumulator adds sn_bit.
- Cycles with sn_valid = 0 are ignored and the window stretches.
- Window completes on the valid sample where sample counter = W−1. That cycle:
  - ones_cnt ← acc + sn_bit;
  - bip_val ← 2·(acc + sn_bit) − W, computed in VAL_W+1 bits, then truncated (always in range);
  - win_len ← W;
  - counters clear;
  - out_valid asserts on the following cycle.
- Windows are back-to-back with no dead cycle. A valid sample arriving on the cycle after completion is counted as sample 0 of the next window.
- Outputs hold their value between pulses.
- Reset values:
  - state IDLE;
  - all counters 0;
  - ones_cnt = 0, bip_val = 0, win_len = 0, out_valid = 0, ema_val = 0.

## Timing
- Latency: last valid sample of a window at edge N → outputs registered at edge N+1, out_valid high N+1..N+2.
- Minimum out_valid spacing is W cycles (continuous sn_valid).
- Asynchronous reset mid-window clears everything immediately. The first window after release starts with the first valid sample once en = 1.
- en falling on the completing sample cycle: the sample is not counted and no pulse is produced (en = 0 takes priority).

## Configuration
- SC_DEC_EMA_EN defined:
  - on each update, ema_val ← ema_val + ((bip_val_new − ema_val) >>> 2);
  - arithmetic shift, computed in VAL_W+1 bits;
  - updated in the same cycle as bip_val.
- Undefined: ema_val is tied to 0 and no EMA logic is synthesized.

## Structure
- Shared package sc_pkg holds:
  - CNT_W/VAL_W defaults;
  - the FSM state enum;
  - the win_sel → W decode function;
  - the SC_DEC_EMA shift constant (2).
- One natural sub-module: sc_win_counter (sample counter plus ones accumulator with terminal-count flag). FSM, output registers and EMA stay in the top.

## Test plan
- en = 1, win_sel = 0, sn_valid = 1, sn_bit = 1 for 8 cycles → one out_valid, ones_cnt = 8, bip_val = +8, win_len = 8.
- win_sel = 1, alternating 1/0 for 16 valid cycles → ones_cnt = 8, bip_val = 0; a second window back-to-back gives an identical result with no gap.
- win_sel = 3, all zeros → ones_cnt = 0, bip_val = −64, pulse exactly 64 cycles after the start.
- win_sel = 0, sn_valid toggling every other cycle with sn_bit = 1 → pulse after 16 cycles, ones_cnt = 8, bip_val = +8.
- win_sel changed 0→2 after 4 samples → first window still W = 8; the next window is W = 32.
- rst_n pulsed high after 5 samples, then released → all outputs 0; the next full window reports only post-reset samples. With SC_DEC_EMA_EN, three windows of bip_val = +8 give ema_val = 2, 3, 4.
